// File: rtl/pool_bram_ctrl_pkg.sv
// rtl/pool_bram_ctrl_pkg.sv - shared types and constants for the pooling BRAM controller
package pool_bram_ctrl_pkg;

    localparam int PIX_W       = 8;
    localparam int WIN_PIX     = 16;
    localparam int WIN_W       = PIX_W * WIN_PIX;
    localparam int POOL_W      = 4 * PIX_W;
    localparam int TILE_CYCLES = 22;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_POOL  = 3'd2,
        ST_WRITE = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    // Bit offset of window slot idx (r-major 4x4) inside the packed window.
    function automatic logic [6:0] pix_lsb(input logic [3:0] idx);
        return {idx, 3'b000};
    endfunction

endpackage

// File: rtl/pool_bram_if.sv
// rtl/pool_bram_if.sv - control, source-read, window and destination-write bundle
interface pool_bram_if #(
    parameter int ADDR_W = 16
) ();

    logic                                   start;
    logic                                   busy;
    logic                                   done;
    logic                                   rd_en;
    logic [ADDR_W-1:0]                      rd_addr;
    logic [pool_bram_ctrl_pkg::PIX_W-1:0]   rd_data;
    logic [pool_bram_ctrl_pkg::WIN_W-1:0]   win;
    logic [pool_bram_ctrl_pkg::POOL_W-1:0]  pool_out;
    logic                                   wr_en;
    logic [ADDR_W-1:0]                      wr_addr;
    logic [pool_bram_ctrl_pkg::PIX_W-1:0]   wr_data;

    modport master (
        input  start, rd_data, pool_out,
        output busy, done, rd_en, rd_addr, win, wr_en, wr_addr, wr_data
    );

    modport slave (
        output start, rd_data, pool_out,
        input  busy, done, rd_en, rd_addr, win, wr_en, wr_addr, wr_data
    );

endinterface

// File: rtl/pool_tile_addr_gen.sv
// rtl/pool_tile_addr_gen.sv - tile origin, pixel and byte counters with read/write address generation
module pool_tile_addr_gen
    import pool_bram_ctrl_pkg::*;
#(
    parameter int IMG_W  = 8,
    parameter int IMG_H  = 8,
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              fetch_inc,
    input  logic              write_inc,
    input  logic              tile_adv,
    output logic [3:0]        pix_slot,
    output logic              fetch_done,
    output logic [1:0]        byte_idx,
    output logic              last_tile,
    output logic [ADDR_W-1:0] rd_addr,
    output logic [ADDR_W-1:0] wr_addr
);

    localparam logic [ADDR_W-1:0] W_A  = ADDR_W'(IMG_W);
    localparam logic [ADDR_W-1:0] OW_A = ADDR_W'(IMG_W - 2);
    localparam logic [ADDR_W-1:0] OH_A = ADDR_W'(IMG_H - 2);
    localparam logic [ADDR_W-1:0] TWO  = ADDR_W'(2);

    logic [ADDR_W-1:0] tx;
    logic [ADDR_W-1:0] ty;
    logic [4:0]        pix_idx;
    logic              x_wrap;

    assign x_wrap     = (tx + TWO) == OW_A;
    assign last_tile  = x_wrap && ((ty + TWO) == OH_A);
    assign pix_slot   = pix_idx[3:0];
    assign fetch_done = (pix_idx == 5'(WIN_PIX));

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            tx       <= '0;
            ty       <= '0;
            pix_idx  <= '0;
            byte_idx <= '0;
        end else if (tile_adv) begin
            pix_idx  <= '0;
            byte_idx <= '0;
            if (x_wrap) begin
                tx <= '0;
                ty <= ty + TWO;
            end else begin
                tx <= tx + TWO;
            end
        end else begin
            if (fetch_inc) pix_idx  <= pix_idx + 5'd1;
            if (write_inc) byte_idx <= byte_idx + 2'd1;
        end
    end

    // Source pixel (ty+r, tx+c) with r/c taken from the r-major window slot.
    assign rd_addr = (ty + ADDR_W'(pix_idx[3:2])) * W_A + tx + ADDR_W'(pix_idx[1:0]);

    // Byte order walks down first: (ty,tx), (ty+1,tx), (ty,tx+1), (ty+1,tx+1).
    assign wr_addr = (ty + ADDR_W'(byte_idx[0])) * OW_A + tx + ADDR_W'(byte_idx[1]);

endmodule

// File: rtl/pool_bram_ctrl.sv
// rtl/pool_bram_ctrl.sv - 4x4 window fetch / 2x2 result write-back controller; POOL_PERF_CNT_EN adds cycle_cnt
module pool_bram_ctrl
    import pool_bram_ctrl_pkg::*;
#(
    parameter int IMG_W  = 8,
    parameter int IMG_H  = 8,
    parameter int ADDR_W = 16
) (
    input  logic        clk,
    input  logic        rst,
    pool_bram_if.master bus
`ifdef POOL_PERF_CNT_EN
    ,
    output logic [31:0] cycle_cnt
`endif
);

    state_t state;
    state_t state_nxt;

    logic              busy;
    logic              done;
    logic              rd_en;
    logic              wr_en;
    logic              clr;
    logic              tile_adv;
    logic [3:0]        pix_slot;
    logic              fetch_done;
    logic [1:0]        byte_idx;
    logic              last_tile;
    logic [ADDR_W-1:0] rd_addr;
    logic [ADDR_W-1:0] wr_addr;

    logic [WIN_W-1:0]  win_q;
    logic [POOL_W-1:0] pool_q;
    logic              cap_vld;
    logic [3:0]        cap_idx;

    pool_tile_addr_gen #(
        .IMG_W  (IMG_W),
        .IMG_H  (IMG_H),
        .ADDR_W (ADDR_W)
    ) u_addr_gen (
        .clk        (clk),
        .rst        (rst),
        .clr        (clr),
        .fetch_inc  (rd_en),
        .write_inc  (wr_en),
        .tile_adv   (tile_adv),
        .pix_slot   (pix_slot),
        .fetch_done (fetch_done),
        .byte_idx   (byte_idx),
        .last_tile  (last_tile),
        .rd_addr    (rd_addr),
        .wr_addr    (wr_addr)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    // FETCH holds one cycle past the last read so the 16th byte lands in the window.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (bus.start)     state_nxt = ST_FETCH;
            ST_FETCH: if (fetch_done)    state_nxt = ST_POOL;
            ST_POOL:                     state_nxt = ST_WRITE;
            ST_WRITE: if (byte_idx == 2'd3)
                          state_nxt = last_tile ? ST_DONE : ST_FETCH;
            ST_DONE:                     state_nxt = ST_IDLE;
            default:                     state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        busy     = 1'b0;
        done     = 1'b0;
        rd_en    = 1'b0;
        wr_en    = 1'b0;
        clr      = 1'b0;
        tile_adv = 1'b0;
        case (state)
            ST_IDLE:  clr = bus.start;
            ST_FETCH: begin
                busy  = 1'b1;
                rd_en = !fetch_done;
            end
            ST_POOL:  busy = 1'b1;
            ST_WRITE: begin
                busy     = 1'b1;
                wr_en    = 1'b1;
                tile_adv = (byte_idx == 2'd3) && !last_tile;
            end
            ST_DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            win_q   <= '0;
            pool_q  <= '0;
            cap_vld <= 1'b0;
            cap_idx <= '0;
        end else begin
            cap_vld <= rd_en;
            cap_idx <= pix_slot;
            if (cap_vld)
                win_q[pix_lsb(cap_idx) +: PIX_W] <= bus.rd_data;
            if (state == ST_POOL)
                pool_q <= bus.pool_out;
        end
    end

`ifdef POOL_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst || clr) cycle_cnt <= '0;
        else if (busy)  cycle_cnt <= cycle_cnt + 32'd1;
    end
`endif

    assign bus.busy    = busy;
    assign bus.done    = done;
    assign bus.rd_en   = rd_en;
    assign bus.rd_addr = rd_addr;
    assign bus.win     = win_q;
    assign bus.wr_en   = wr_en;
    assign bus.wr_addr = wr_addr;
    assign bus.wr_data = pool_q[{byte_idx, 3'b000} +: PIX_W];

endmodule

// File: tb/tb_pool_bram_ctrl.sv
// tb/tb_pool_bram_ctrl.sv - directed self-checking bench for pool_bram_ctrl (8x8 map)
module tb_pool_bram_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    pool_bram_if #(.ADDR_W(16)) bus ();

`ifdef POOL_PERF_CNT_EN
    logic [31:0] cycle_cnt;
`endif

    pool_bram_ctrl #(
        .IMG_W  (8),
        .IMG_H  (8),
        .ADDR_W (16)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef POOL_PERF_CNT_EN
        ,
        .cycle_cnt (cycle_cnt)
`endif
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] src_mem [64];
    logic [7:0] out_mem [36];
    int         hits    [36];
    int         wr_count;
    int         overlap;
    int         bad_addr;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // External 3x3-max datapath, byte b covers rows b[0].., cols b[1]..
    function automatic logic [31:0] pool_model(input logic [127:0] w);
        logic [7:0] m;
        logic [31:0] res;
        res = '0;
        for (int b = 0; b < 4; b++) begin
            m = 8'd0;
            for (int r = 0; r < 3; r++)
                for (int c = 0; c < 3; c++)
                    if (w[(4 * (r + b % 2) + c + b / 2) * 8 +: 8] > m)
                        m = w[(4 * (r + b % 2) + c + b / 2) * 8 +: 8];
            res[b * 8 +: 8] = m;
        end
        return res;
    endfunction

    always_comb bus.pool_out = pool_model(bus.win);

    always @(posedge clk) begin
        if (bus.rd_en) bus.rd_data <= src_mem[bus.rd_addr[5:0]];
        if (bus.rd_en && bus.wr_en) overlap++;
        if (bus.wr_en) begin
            wr_count++;
            if (bus.wr_addr < 16'd36) begin
                out_mem[bus.wr_addr] = bus.wr_data;
                hits[bus.wr_addr]++;
            end else begin
                bad_addr++;
            end
        end
    end

    task automatic load_img(input int mode);
        for (int i = 0; i < 64; i++) begin
            case (mode)
                0:       src_mem[i] = 8'(i);
                1:       src_mem[i] = (i == 28) ? 8'd0 : 8'd255;
                default: src_mem[i] = 8'd0;
            endcase
        end
    endtask

    task automatic timing_checks(input int cyc);
        case (cyc)
            1: begin
                check("c1_busy", bus.busy, 1);
                check("c1_rd_en", bus.rd_en, 1);
                check("c1_rd_addr", bus.rd_addr, 0);
            end
            2:  check("c2_rd_addr", bus.rd_addr, 1);
            5:  check("c5_rd_addr", bus.rd_addr, 8);
            16: check("c16_rd_addr", bus.rd_addr, 27);
            17: check("c17_rd_en", bus.rd_en, 0);
            18: begin
                check("c18_rdwr", {bus.rd_en, bus.wr_en}, 0);
                check("c18_win_lo", bus.win[31:0], 32'h03020100);
                check("c18_win_hi", bus.win[127:96], 32'h1B1A1918);
            end
            19: check("c19_wr", {bus.wr_en, bus.wr_addr, bus.wr_data}, {1'b1, 16'd0, 8'd18});
            20: check("c20_wr", {bus.wr_en, bus.wr_addr, bus.wr_data}, {1'b1, 16'd6, 8'd26});
            21: check("c21_wr", {bus.wr_en, bus.wr_addr, bus.wr_data}, {1'b1, 16'd1, 8'd19});
            22: check("c22_wr", {bus.wr_en, bus.wr_addr, bus.wr_data}, {1'b1, 16'd7, 8'd27});
            23: check("c23_rd", {bus.rd_en, bus.wr_en, bus.rd_addr}, {1'b1, 1'b0, 16'd2});
            177: check("c177_rd_addr", bus.rd_addr, 36);
            198: check("c198_wr", {bus.wr_addr, bus.wr_data}, {16'd35, 8'd63});
            199: check("c199_done_busy", {bus.done, bus.busy}, 2'b11);
            default: ;
        endcase
    endtask

    task automatic run_pass(input int restart_at, input int rst_at, input bit timing,
                            output int done_cyc, output int stray);
        done_cyc = 0;
        stray    = 0;
        @(negedge clk);
        wr_count = 0;
        overlap  = 0;
        bad_addr = 0;
        for (int i = 0; i < 36; i++) begin
            hits[i]    = 0;
            out_mem[i] = 8'hxx;
        end
        check("c0_idle", bus.busy, 0);
        bus.start = 1'b1;
        @(negedge clk);
        for (int cyc = 1; cyc <= 400; cyc++) begin
            bus.start = (cyc == restart_at);
            if (timing) timing_checks(cyc);
            if (rst_at != 0 && cyc == rst_at) rst = 1'b1;
            if (rst_at != 0 && cyc == rst_at + 1) begin
                check("rst_next", {bus.busy, bus.rd_en, bus.wr_en}, 0);
                rst = 1'b0;
            end
            if (rst_at != 0 && cyc > rst_at && (bus.rd_en || bus.wr_en)) stray++;
            if (bus.done && done_cyc == 0) done_cyc = cyc;
            @(negedge clk);
            if (done_cyc != 0) break;
        end
        bus.start = 1'b0;
    endtask

    task automatic check_pass(input int mode, input int done_cyc);
        int uniq;
        logic [7:0] exp;
        uniq = 0;
        check("done_cycle", done_cyc, 199);
        check("post_busy", {bus.busy, bus.done}, 0);
        check("wr_count", wr_count, 36);
        check("overlap", overlap, 0);
        check("bad_addr", bad_addr, 0);
        for (int i = 0; i < 36; i++) if (hits[i] == 1) uniq++;
        check("addr_once", uniq, 36);
        for (int oy = 0; oy < 6; oy++)
            for (int ox = 0; ox < 6; ox++) begin
                case (mode)
                    0:       exp = 8'((oy + 2) * 8 + ox + 2);
                    1:       exp = 8'd255;
                    default: exp = 8'd0;
                endcase
                check($sformatf("out_m%0d_%0d_%0d", mode, oy, ox), out_mem[oy * 6 + ox], exp);
            end
    endtask

    int dc;
    int st;

    initial begin
        bus.start   = 1'b0;
        bus.rd_data = 8'd0;
        repeat (3) @(negedge clk);
        check("rst_ctrl", {bus.busy, bus.done, bus.rd_en, bus.wr_en}, 0);
        check("rst_rd_addr", bus.rd_addr, 0);
        check("rst_wr", {bus.wr_addr, bus.wr_data}, 0);
        check("rst_win", (bus.win == '0), 1);
`ifdef POOL_PERF_CNT_EN
        check("rst_cycle_cnt", cycle_cnt, 0);
`endif
        rst = 1'b0;

        load_img(0);
        run_pass(0, 0, 1'b1, dc, st);
        check_pass(0, dc);
`ifdef POOL_PERF_CNT_EN
        check("perf_after_done", cycle_cnt, 199);
        repeat (5) @(negedge clk);
        check("perf_hold", cycle_cnt, 199);
`endif

        load_img(1);
        run_pass(0, 0, 1'b0, dc, st);
        check_pass(1, dc);

        load_img(2);
        run_pass(0, 0, 1'b0, dc, st);
        check_pass(2, dc);

        load_img(0);
        run_pass(50, 0, 1'b0, dc, st);
        check_pass(0, dc);
`ifdef POOL_PERF_CNT_EN
        check("perf_restart", cycle_cnt, 199);
`endif

        run_pass(0, 30, 1'b0, dc, st);
        check("abort_no_done", dc, 0);
        check("abort_stray", st, 0);
        check("abort_writes", wr_count, 4);

        run_pass(0, 0, 1'b1, dc, st);
        check_pass(0, dc);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pool_bram_ctrl.md
POOL_BRAM_CTRL -- requirements
Module: pool_bram_ctrl

Interface
REQ-001 Parameter IMG_W, default 8, input map width in pixels; even, >= 4.
REQ-002 Parameter IMG_H, default 8, input map height in pixels; even, >= 4.
REQ-003 Parameter ADDR_W, default 16, BRAM address width.
REQ-004 clk  in  1  single clock; all state changes on rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 start  in  1  begin one full-map pooling pass.
REQ-007 busy  out  1  high while a pass runs.
REQ-008 done  out  1  one-cycle pulse at pass end.
REQ-009 rd_en / rd_addr  out  1 / ADDR_W  source BRAM read request and address.
REQ-010 rd_data  in  8  source pixel, valid the cycle after rd_en.
REQ-011 win  out  128  assembled 4x4 window; pixel (r,c) at bits [(4r+c)*8 +: 8].
REQ-012 pool_out  in  32  combinational 3x3-max result of win from the external pooling datapath.
REQ-013 wr_en / wr_addr / wr_data  out  1 / ADDR_W / 8  destination BRAM write port.

Function
REQ-014 Output map: OW = IMG_W-2, OH = IMG_H-2; tiles stepped by 2 in x and y, raster order; TILES = (OW/2)*(OH/2).
REQ-015 FSM states IDLE, FETCH, POOL, WRITE, DONE; IDLE->FETCH on start; FETCH->POOL after 16th pixel captured; POOL->WRITE; WRITE->FETCH (more tiles) or DONE (last tile); DONE->IDLE unconditionally.
REQ-016 Cycle 0 = edge at which start is sampled in IDLE; busy high from cycle 1 until the done cycle inclusive.
REQ-017 FETCH: cycles 1..16 of a tile assert rd_en, address (ty+r)*IMG_W+(tx+c), r-major; each byte captured the following cycle into win.
REQ-018 POOL: one cycle (tile cycle 18); pool_out registered at its end.
REQ-019 WRITE: tile cycles 19..22, one byte per cycle, order byte0..byte3 -> output pixels (ty,tx), (ty+1,tx), (ty,tx+1), (ty+1,tx+1); wr_addr = oy*OW+ox.
REQ-020 Each tile takes exactly 22 cycles; done asserted in cycle TILES*22+1.
REQ-021 start while busy is ignored; no queuing.
REQ-022 rd_en and wr_en are never asserted in the same cycle; neither is asserted outside FETCH/WRITE.
REQ-023 Tile x counter wraps to 0 and y increments when tx+2 = OW; pass ends when ty+2 = OH after the last write.

Reset
REQ-024 rst forces IDLE; busy, done, rd_en, wr_en = 0; rd_addr, wr_addr, wr_data, win, counters = 0.
REQ-025 rst mid-pass aborts immediately: no further reads or writes, no done pulse; rst has priority over start.

Configuration
REQ-026 Macro POOL_PERF_CNT_EN defined: extra output cycle_cnt (32 bits), cleared on start acceptance, increments every busy cycle, holds after done, reset to 0.
REQ-027 Macro absent: no cycle_cnt port, no counter logic; all other behaviour identical.

Structure
REQ-028 Shared package holds the FSM state encoding, window/pixel widths (8, 16 pixels, 128 bits) and per-tile cycle count (22).
REQ-029 One natural sub-module: pool_tile_addr_gen (tile/pixel counters, rd_addr and wr_addr generation).

Verification
REQ-030 8x8 ramp pixel=y*8+x, start -> 36 writes, output (oy,ox) = (oy+2)*8+ox+2, done in cycle 199.
REQ-031 Constant image 255 with one pixel 0 -> all 36 outputs 255; all-zero image -> all outputs 0.
REQ-032 start pulsed again at cycle 50 -> ignored, pass and write count unchanged.
REQ-033 rst at cycle 30 -> next cycle busy=0, rd_en=0, wr_en=0, no done; new start runs a full correct pass.
REQ-034 Protocol monitor over full pass: rd_en and wr_en never concurrently high, write addresses 0..35 each exactly once.
REQ-035 With POOL_PERF_CNT_EN, 8x8 pass -> cycle_cnt = 199 after done, holds until next start.
